// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, buffered ALU result record and occupancy encoding
package alu_pkg;
  localparam int DATA_W = 64;
  localparam int RD_W = 5;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              we;
  } ex_result_t;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
endpackage

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: two-entry in-order elastic buffer from EX to MEM with operand forwarding
//   in_*  : ALU result handshake (in_ready registered, independent of out_ready)
//   out_* : head entry towards MEM
//   fwd_* : combinational lookup of buffered results, newest first
//   flush : synchronous discard of all entries, dominates any accept
module ex_result_buffer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  input  logic [RD_W-1:0]   fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);
  logic [1:0] state_q, state_d;
  logic init_done_q;
  ex_result_t e0_q, e0_d, e1_q, e1_d, in_e;
  logic acc, emit, hit0, hit1, rs_nz;
  assign in_e = '{data: in_data, rd: in_rd, we: in_we};
  assign in_ready = (state_q != TWO) && init_done_q;
  assign out_valid = state_q != EMPTY;
  assign out_data = e0_q.data;
  assign out_rd = e0_q.rd;
  assign out_we = out_valid && e0_q.we;
  assign acc = in_valid && in_ready;
  assign emit = out_valid && out_ready;
  // TWO never accepts and EMPTY never emits, so the count cannot wrap
  always_comb begin
    state_d = flush ? EMPTY : state_q + {1'b0, acc} - {1'b0, emit};
    e0_d = (acc && (state_q == EMPTY || emit)) ? in_e :
           (state_q == TWO && emit) ? e1_q : e0_q;
    e1_d = (acc && state_q == ONE && !emit) ? in_e : e1_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_done_q <= 1'b1;
    end
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
  assign rs_nz = fwd_rs != '0;
  assign hit0 = out_valid && e0_q.we && e0_q.rd == fwd_rs;
  assign hit1 = state_q == TWO && e1_q.we && e1_q.rd == fwd_rs;
  assign fwd_hit = rs_nz && (hit0 || hit1);
  assign fwd_data = !rs_nz ? '0 : hit1 ? e1_q.data : hit0 ? e0_q.data : '0;
endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer: directed self-checking bench for ex_result_buffer
module tb_ex_result_buffer;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_we = 0, out_ready = 0;
  logic [DATA_W-1:0] in_data = '0;
  logic [RD_W-1:0] in_rd = '0, fwd_rs = '0;
  logic in_ready, out_valid, out_we, fwd_hit;
  logic [DATA_W-1:0] out_data, fwd_data;
  logic [RD_W-1:0] out_rd;
  int checks = 0, failures = 0;
  ex_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] d, input logic [4:0] rd, input logic we);
    in_valid = 1; in_data = d; in_rd = rd; in_we = we;
  endtask
  initial begin
    push(64'h99, 5'd1, 1'b1);
    fwd_rs = 5'd1;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_out_we", out_we, 0);
    rst_n = 1; in_valid = 0; fwd_rs = 0;
    #1 chk("init_not_ready", in_ready, 0);
    tick;
    chk("init_ready", in_ready, 1);
    chk("init_empty", out_valid, 0);
    out_ready = 1;
    push(64'h1, 5'd1, 1'b1);
    tick;
    chk("str_v1", out_valid, 1);
    chk("str_d1", out_data, 64'h1);
    chk("str_rd1", out_rd, 1);
    push(64'h2, 5'd2, 1'b1);
    tick;
    chk("str_d2", out_data, 64'h2);
    chk("str_rdy2", in_ready, 1);
    push(64'h3, 5'd3, 1'b1);
    tick;
    chk("str_d3", out_data, 64'h3);
    chk("str_rd3", out_rd, 3);
    in_valid = 0;
    tick;
    chk("str_drained", out_valid, 0);
    out_ready = 0;
    push(64'hAAAA, 5'd4, 1'b1);
    tick;
    chk("bp_rdy1", in_ready, 1);
    chk("bp_d1", out_data, 64'hAAAA);
    push(64'hBBBB, 5'd4, 1'b1);
    tick;
    chk("bp_full", in_ready, 0);
    chk("bp_head", out_data, 64'hAAAA);
    push(64'hCCCC, 5'd4, 1'b1);
    tick;
    chk("bp_held", in_ready, 0);
    chk("bp_head2", out_data, 64'hAAAA);
    out_ready = 1;
    tick;
    chk("bp_d2", out_data, 64'hBBBB);
    chk("bp_rdy2", in_ready, 1);
    tick;
    chk("bp_d3", out_data, 64'hCCCC);
    chk("bp_v3", out_valid, 1);
    in_valid = 0;
    tick;
    chk("bp_drained", out_valid, 0);
    out_ready = 0;
    push(64'h11, 5'd7, 1'b1);
    tick;
    push(64'h22, 5'd7, 1'b1);
    tick;
    chk("fl_full", in_ready, 0);
    flush = 1; push(64'hDEAD, 5'd7, 1'b1);
    tick;
    chk("fl_v", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    flush = 0; in_valid = 0;
    tick;
    chk("fl_no_dead", out_valid, 0);
    push(64'h33, 5'd7, 1'b1);
    tick;
    chk("fl1_v", out_valid, 1);
    flush = 1; push(64'hDEAD, 5'd7, 1'b1);
    tick;
    chk("fl1_drop", out_valid, 0);
    flush = 0; in_valid = 0;
    tick;
    chk("fl1_empty", out_valid, 0);
    push(64'h10, 5'd5, 1'b1);
    tick;
    push(64'h20, 5'd5, 1'b1);
    tick;
    in_valid = 0; fwd_rs = 5'd5;
    #1;
    chk("fw_tail_hit", fwd_hit, 1);
    chk("fw_tail_data", fwd_data, 64'h20);
    fwd_rs = 5'd0;
    #1;
    chk("fw_zero_hit", fwd_hit, 0);
    chk("fw_zero_data", fwd_data, 0);
    flush = 1;
    tick;
    flush = 0;
    push(64'h10, 5'd5, 1'b1);
    tick;
    push(64'h20, 5'd5, 1'b0);
    tick;
    in_valid = 0; fwd_rs = 5'd5;
    #1;
    chk("fw_head_hit", fwd_hit, 1);
    chk("fw_head_data", fwd_data, 64'h10);
    fwd_rs = 5'd3;
    #1;
    chk("fw_miss", fwd_hit, 0);
    chk("fw_miss_data", fwd_data, 0);
    fwd_rs = 5'd5; out_ready = 1;
    tick;
    chk("we0_v", out_valid, 1);
    chk("we0_d", out_data, 64'h20);
    chk("we0_we", out_we, 0);
    chk("we0_nohit", fwd_hit, 0);
    out_ready = 0;
    push(64'h44, 5'd6, 1'b1);
    tick;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_v", out_valid, 0);
    chk("arst_rdy", in_ready, 0);
    tick;
    rst_n = 1;
    tick;
    chk("arst_rel", in_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Two-entry elastic buffer between the registered ALU outputs (and, or, add, shift units) and the MEM stage of the 5-stage pipeline. It accepts one ALU result per cycle with a valid/ready handshake and presents results to MEM in order. Its registered `in_ready` breaks the combinational stall path from MEM back into EX. It also exposes a forwarding port so the EX operand muxes can pick up results still held in the buffer.

## Interface
- `DATA_W`, 64, ALU result width
- `RD_W`, 5, destination register index width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous discard of all entries (branch mispredict/exception)
- `in_valid`  in  1  ALU result valid
- `in_ready`  out  1  buffer can accept this cycle
- `in_data`  in  DATA_W  ALU result
- `in_rd`  in  RD_W  destination register
- `in_we`  in  1  register-write enable for this result
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  MEM stage accepts head
- `out_data` / `out_rd` / `out_we`  out  DATA_W / RD_W / 1  head entry fields
- `fwd_rs`  in  RD_W  operand register being looked up
- `fwd_hit`  out  1  buffered result matches `fwd_rs`
- `fwd_data`  out  DATA_W  forwarded value

## Operation
- Occupancy state: EMPTY (0), ONE (1), TWO (2), held in a registered 2-bit count. Entry 0 is the head and entry 1 the tail.
- Accept when `in_valid & in_ready`. Emit when `out_valid & out_ready`.
- `in_ready` = (state != TWO) && `init_done`. `init_done` is a flop cleared by reset and set on the first clock edge after `rst_n` rises.
- `out_valid` = (state != EMPTY). Output fields are driven from the entry 0 registers only.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept without emit → TWO, new entry goes to entry 1.
  - ONE + accept with emit → ONE, new entry is written to entry 0.
  - ONE + emit only → EMPTY.
  - TWO + emit → ONE, entry 1 shifts to entry 0.
  - TWO never accepts.
- `flush` has priority over everything else. The next state is EMPTY and any accept in that cycle is dropped. An emit in the flush cycle counts as delivered to MEM.
- Entries with `in_we=0` are buffered and delivered like any other entry.
- Forwarding is combinational from the registered state and `fwd_rs`:
  - Candidates are valid entries with `we=1` and `rd == fwd_rs`, and `fwd_rs != 0`.
  - The tail (newest) takes priority over the head.
  - `fwd_data` = 0 when there is no hit.
- Entry data registers are not reset. Only state, `init_done` and the outputs derived from them are reset.

## Timing
- Reset values while `rst_n` is low: state EMPTY, `out_valid=0`, `in_ready=0`, `fwd_hit=0`, `fwd_data=0`, `out_we=0`.
- Latency: a result accepted at edge N is visible on `out_*` after edge N, i.e. in cycle N+1.
- Throughput: one result per cycle when `out_ready` is held high.
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- A flush asserted at edge N gives `out_valid=0` and `in_ready=1` in cycle N+1.
- `rst_n` asserted mid-operation empties the buffer immediately, without waiting for a clock edge.

## Structure
- Shared package `alu_pkg`:
  - `DATA_W` and `RD_W` constants.
  - `ex_result_t` packed struct holding data, rd and we.
  - State encoding constants EMPTY, ONE, TWO.
- Single module; no sub-module is warranted. The forwarding compare is two equality checks kept inline.

## Test plan
- Reset and init: hold `rst_n`=0 for 3 cycles with `in_valid=1` → `in_ready=0` and `out_valid=0`. One cycle after release `in_ready=1`, and the first accept lands on the following edge.
- Streaming: push data 0x1, 0x2, 0x3 with rd 1/2/3 and `out_ready=1` → `out_data` shows 0x1, 0x2, 0x3 in consecutive cycles, starting one cycle after the first accept.
- Backpressure: `out_ready=0`, push 0xAAAA and 0xBBBB → `in_ready=0` after the second accept. A third push of 0xCCCC is held off until `out_ready=1`. Output order is 0xAAAA, 0xBBBB, 0xCCCC with no loss or duplication.
- Flush: buffer holds two entries, then assert `flush` together with a new `in_valid` of 0xDEAD → next cycle `out_valid=0` and `in_ready=1`, and 0xDEAD never appears on the output.
- Forwarding priority: buffer holds head rd=5 data 0x10 we=1 and tail rd=5 data 0x20 we=1. With `fwd_rs=5` → `fwd_hit=1`, `fwd_data=0x20`. Change the tail to we=0 → `fwd_data=0x10`. With `fwd_rs=0` → `fwd_hit=0`.
- Simultaneous accept and emit in state ONE with `out_ready=1` → state stays ONE, `out_data` equals the new value next cycle, and `in_ready` stays 1.
